// File: rtl/multi_serializer.sv
// Multi-lane parallel-to-serial converter: buffers one CHANNELS x WIDTH word and
// shifts every lane out in lockstep on bit_en strobes, falling back to IDLE_WORD.
module multi_serializer #(
   parameter int               WIDTH     = 10,
   parameter int               CHANNELS  = 3,
   parameter bit               LSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      bit_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       serial_out,
   output logic                      word_start,
   output logic                      underflow
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [CHANNELS-1:0][WIDTH-1:0] shift_q;
   logic [CNT_W-1:0]               bit_cnt;
   logic [CHANNELS*WIDTH-1:0]      hold;
   logic                           hold_full;

   // Accept and drain never coincide: accept needs an empty buffer, drain a full one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            shift_q[c] <= IDLE_WORD;
         end
         bit_cnt   <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         underflow <= 1'b0;
      end else begin
         underflow <= 1'b0;
         if (in_valid && !hold_full) begin
            hold      <= in_data;
            hold_full <= 1'b1;
         end
         if (bit_en) begin
            if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               if (hold_full) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     shift_q[c] <= hold[c*WIDTH +: WIDTH];
                  end
                  hold_full <= 1'b0;
               end else begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     shift_q[c] <= IDLE_WORD;
                  end
                  underflow <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               for (int c = 0; c < CHANNELS; c++) begin
                  if (LSB_FIRST) begin
                     shift_q[c] <= {1'b0, shift_q[c][WIDTH-1:1]};
                  end else begin
                     shift_q[c] <= {shift_q[c][WIDTH-2:0], 1'b0};
                  end
               end
            end
         end
      end
   end

   // Outputs are taken directly from registers so the pad path stays glitch-free.
   always_comb begin
      serial_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         serial_out[c] = LSB_FIRST ? shift_q[c][0] : shift_q[c][WIDTH-1];
      end
   end

   assign in_ready   = ~hold_full;
   assign word_start = (bit_cnt == '0);

endmodule
